dbus_mem_responder: RTL and testbench
=====================================

DBUS_MEM_RESPONDER -- requirements
Module: dbus_mem_responder

Interface
REQ-001 Parameter DEPTH, 1024, number of 64-bit words in backing store; power of two.
REQ-002 Parameter LATENCY, 2, cycles from the acceptance edge to data_ok; legal range 1..15.
REQ-003 Parameter BASE_ADDR, 64'h8000_0000, byte address mapped to word 0.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 dreq  input  dbus_req_t  data-bus request from the core: valid, addr, size, strobe[7:0], data[63:0].
REQ-007 dresp  output  dbus_resp_t  response: addr_ok, data_ok, data[63:0].
REQ-008 busy  output  1  high while a transaction is accepted but not yet completed.
REQ-009 err  output  1  sticky out-of-range flag.
REQ-010 rd_cnt  output  32  completed read transactions (strobe == 0).
REQ-011 wr_cnt  output  32  completed write transactions (strobe != 0).

Function
REQ-012 FSM states SHALL be IDLE, BUSY and RESP, all outputs registered.
REQ-013 IDLE with dreq.valid=1 at a posedge SHALL accept: latch addr, strobe, data, load latency counter with LATENCY-1, go BUSY if LATENCY>1, else go RESP.
REQ-014 IDLE with dreq.valid=0 SHALL stay IDLE; no outputs asserted.
REQ-015 dresp.addr_ok SHALL be a one-cycle pulse in the first cycle after the acceptance edge.
REQ-016 BUSY SHALL decrement the counter each cycle and go RESP when the counter reaches 1.
REQ-017 dresp.data_ok SHALL be high exactly one cycle (RESP), the LATENCY-th cycle after the acceptance edge; RESP always returns to IDLE.
REQ-018 With LATENCY=1, addr_ok and data_ok SHALL coincide in the same cycle.
REQ-019 Once accepted, the transaction SHALL complete on latched fields regardless of dreq.valid or changes to dreq fields during BUSY.
REQ-020 A request valid in the cycle immediately after data_ok SHALL be accepted (back-to-back throughput = one transaction per LATENCY+1 cycles).
REQ-021 Word index = (addr - BASE_ADDR) >> 3; addr[2:0] ignored for indexing; in range iff addr >= BASE_ADDR and index < DEPTH.
REQ-022 Read (strobe == 0), in range: dresp.data SHALL equal the stored word during the data_ok cycle.
REQ-023 Write (strobe != 0), in range: byte i of the word SHALL be updated from data byte i iff strobe[i]=1, at the RESP edge; dresp.data SHALL equal the pre-write word.
REQ-024 Out of range: reads return 64'h0, writes are dropped, err set to 1 at the RESP edge; data_ok still asserted with normal latency.
REQ-025 dresp.data SHALL be 64'h0 whenever data_ok=0.
REQ-026 dreq.size SHALL not affect storage; strobe alone selects written bytes.
REQ-027 rd_cnt/wr_cnt SHALL increment at the RESP edge of the corresponding transaction, wrapping 32'hFFFF_FFFF -> 0.
REQ-028 busy SHALL be 1 in BUSY and RESP, 0 in IDLE.

Reset
REQ-029 reset SHALL force IDLE, counter 0, addr_ok=0, data_ok=0, dresp.data=0, busy=0, err=0, rd_cnt=0, wr_cnt=0.
REQ-030 reset asserted during BUSY or RESP SHALL abandon the transaction: no write performed, no data_ok pulse, no counter increment.
REQ-031 Backing store contents SHALL NOT be cleared by reset.
REQ-032 reset SHALL take priority over an acceptance in the same cycle.

Verification
REQ-033 LATENCY=2: write addr 0x8000_0008, strobe 0xFF, data 0x1122334455667788 -> addr_ok cycle 1, data_ok cycle 2; subsequent read of 0x8000_0008 returns 0x1122334455667788, wr_cnt=1, rd_cnt=1.
REQ-034 Partial write strobe 0x0F, data 0xAAAAAAAA_BBBBBBBB over 0x1122334455667788 -> read returns 0x11223344_BBBBBBBB.
REQ-035 LATENCY=1, back-to-back reads with valid held -> data_ok every second cycle, addr_ok coincident with data_ok.
REQ-036 Read of 0x7FFF_FFF8 and write to BASE_ADDR+8*DEPTH -> data 0, err=1 sticky until reset, memory unchanged.
REQ-037 reset pulsed in the BUSY cycle of a write (LATENCY=3) -> no data_ok, wr_cnt=0, target word unchanged on later read.
REQ-038 dreq.valid dropped and addr changed after acceptance -> data_ok still at LATENCY, data from originally latched address.

Source files
------------

// File: rtl/dbus_mem_responder.sv
// Data-bus memory responder: fixed-latency 64-bit backing store for a core dbus.
// Ports: clk, reset (sync, active-high), dreq in, dresp/busy/err/rd_cnt/wr_cnt out.
package dbus_pkg;
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;
endpackage

module dbus_mem_responder
    import dbus_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 2,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  dbus_req_t   dreq,
    output dbus_resp_t  dresp,
    output logic        busy,
    output logic        err,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t state;
    state_t state_nx;
    logic [3:0] cnt;
    logic [3:0] cnt_nx;

    logic [IW-1:0] idx_q;
    logic          hit_q;
    logic [7:0]    strb_q;
    logic [63:0]   wdata_q;

    logic [63:0] mem [DEPTH];

    logic [63:0]   off;
    logic          req_hit;
    logic [IW-1:0] req_idx;
    logic          accept;
    logic [IW-1:0] rd_idx;
    logic          rd_hit;
    logic [63:0]   rd_word;
    logic          unused_ok;

    assign off     = dreq.addr - BASE_ADDR;
    assign req_hit = (dreq.addr >= BASE_ADDR) && (off[63:3] < 61'(DEPTH));
    assign req_idx = off[IW+2:3];
    assign accept  = (state == IDLE) && dreq.valid;

    // Size and the byte offset never influence storage.
    assign unused_ok = ^{off[2:0], dreq.size};

    // With LATENCY=1 the read happens on the acceptance edge itself,
    // so the live request index is used; otherwise the latched one.
    assign rd_idx  = (state == IDLE) ? req_idx : idx_q;
    assign rd_hit  = (state == IDLE) ? req_hit : hit_q;
    assign rd_word = mem[rd_idx];

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (dreq.valid) begin
                    cnt_nx   = 4'(LATENCY - 1);
                    state_nx = (LATENCY > 1) ? BUSY : RESP;
                end
            end
            BUSY: begin
                if (cnt == 4'd1) begin
                    cnt_nx   = 4'd0;
                    state_nx = RESP;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            dresp   <= '0;
            busy    <= 1'b0;
            err     <= 1'b0;
            rd_cnt  <= 32'd0;
            wr_cnt  <= 32'd0;
            idx_q   <= '0;
            hit_q   <= 1'b0;
            strb_q  <= 8'd0;
            wdata_q <= 64'd0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            dresp.addr_ok <= accept;
            dresp.data_ok <= (state_nx == RESP);
            // Pre-write word, or zero when out of range / not responding.
            dresp.data    <= ((state_nx == RESP) && rd_hit) ? rd_word : 64'd0;
            busy          <= (state_nx != IDLE);
            if (accept) begin
                idx_q   <= req_idx;
                hit_q   <= req_hit;
                strb_q  <= dreq.strobe;
                wdata_q <= dreq.data;
            end
            if (state == RESP) begin
                if (!hit_q) begin
                    err <= 1'b1;
                end
                if (strb_q == 8'd0) begin
                    rd_cnt <= rd_cnt + 32'd1;
                end else begin
                    wr_cnt <= wr_cnt + 32'd1;
                end
            end
        end
    end

    // Store is never cleared; a reset in RESP suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset && (state == RESP) && hit_q && (strb_q != 8'd0)) begin
            for (int i = 0; i < 8; i++) begin
                if (strb_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_dbus_mem_responder.sv
// Scoreboard bench for dbus_mem_responder at LATENCY 2, 1 and 3.
// Stimulus pushes expected addr_ok/data_ok events; a monitor pops them.
module tb_dbus_mem_responder;
    import dbus_pkg::*;

    localparam logic [63:0] B = 64'h8000_0000;

    typedef struct {
        int          u;
        int          cyc;
        logic [63:0] d;
        bit          chk;
    } ent_t;

    typedef struct {
        int u;
        int cyc;
    } aok_t;

    logic        clk;
    logic        rst  [3];
    dbus_req_t   req  [3];
    dbus_resp_t  resp [3];
    logic        busy [3];
    logic        err  [3];
    logic [31:0] rdc  [3];
    logic [31:0] wrc  [3];

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 0;
    ent_t dq[$];
    aok_t aq[$];

    dbus_mem_responder #(.LATENCY(2)) u0 (
        .clk(clk), .reset(rst[0]), .dreq(req[0]), .dresp(resp[0]),
        .busy(busy[0]), .err(err[0]), .rd_cnt(rdc[0]), .wr_cnt(wrc[0])
    );
    dbus_mem_responder #(.DEPTH(16), .LATENCY(1)) u1 (
        .clk(clk), .reset(rst[1]), .dreq(req[1]), .dresp(resp[1]),
        .busy(busy[1]), .err(err[1]), .rd_cnt(rdc[1]), .wr_cnt(wrc[1])
    );
    dbus_mem_responder #(.DEPTH(16), .LATENCY(3)) u2 (
        .clk(clk), .reset(rst[2]), .dreq(req[2]), .dresp(resp[2]),
        .busy(busy[2]), .err(err[2]), .rd_cnt(rdc[2]), .wr_cnt(wrc[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(int u);
        return (u == 0) ? 2 : (u == 1) ? 1 : 3;
    endfunction

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        ent_t e;
        aok_t a;
        if (mon_en) begin
            for (int u = 0; u < 3; u++) begin
                if (resp[u].addr_ok) begin
                    if (aq.size() == 0) begin
                        check($sformatf("addr_ok_spurious%0d", u), 1, 0);
                    end else begin
                        a = aq.pop_front();
                        check("addr_ok_unit", 64'(u), 64'(a.u));
                        check("addr_ok_cycle", 64'(cyc), 64'(a.cyc));
                    end
                end
                if (resp[u].data_ok) begin
                    if (dq.size() == 0) begin
                        check($sformatf("data_ok_spurious%0d", u), 1, 0);
                    end else begin
                        e = dq.pop_front();
                        check("data_ok_unit", 64'(u), 64'(e.u));
                        check("data_ok_cycle", 64'(cyc), 64'(e.cyc));
                        if (e.chk) check("resp_data", resp[u].data, e.d);
                    end
                end else begin
                    check($sformatf("idle_data_zero%0d", u), resp[u].data, 64'd0);
                end
            end
        end
    end

    // Called at a negedge in an IDLE cycle; returns at the next IDLE cycle.
    // After acceptance the request fields are scrambled to prove latching.
    task automatic issue(int u, logic [63:0] a, logic [7:0] s,
                         logic [63:0] d, logic [63:0] x, bit chk);
        int l;
        l = lat_of(u);
        aq.push_back('{u: u, cyc: cyc + 1});
        dq.push_back('{u: u, cyc: cyc + l, d: x, chk: chk});
        req[u].valid  = 1'b1;
        req[u].addr   = a;
        req[u].strobe = s;
        req[u].data   = d;
        req[u].size   = 3'd3;
        @(negedge clk);
        req[u].valid  = 1'b0;
        req[u].addr   = B + 64'h10;
        req[u].strobe = 8'hFF;
        req[u].data   = 64'hDEAD_BEEF_DEAD_BEEF;
        req[u].size   = 3'd0;
        repeat (l) @(negedge clk);
    endtask

    initial begin
        for (int u = 0; u < 3; u++) begin
            req[u] = '0;
            rst[u] = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 3; u++) rst[u] = 1'b0;
        mon_en = 1'b1;
        for (int u = 0; u < 3; u++) begin
            check($sformatf("rst_addr_ok%0d", u), resp[u].addr_ok, 0);
            check($sformatf("rst_data_ok%0d", u), resp[u].data_ok, 0);
            check($sformatf("rst_busy%0d", u), busy[u], 0);
            check($sformatf("rst_err%0d", u), err[u], 0);
            check($sformatf("rst_rdc%0d", u), rdc[u], 0);
            check($sformatf("rst_wrc%0d", u), wrc[u], 0);
        end

        // LATENCY=2: full write, read back, partial write, read back
        issue(0, B + 8, 8'hFF, 64'h1122334455667788, 64'h0, 0);
        issue(0, B + 8, 8'h00, 64'h0, 64'h1122334455667788, 1);
        check("wr_cnt_a", wrc[0], 1);
        check("rd_cnt_a", rdc[0], 1);
        check("err_a", err[0], 0);
        issue(0, B + 8, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, 64'h1122334455667788, 1);
        issue(0, B + 64'hF, 8'h00, 64'h0, 64'h11223344_BBBBBBBB, 1);
        check("wr_cnt_b", wrc[0], 2);
        check("rd_cnt_b", rdc[0], 2);

        // Out of range on both sides; word 0 must survive the aliasing write
        issue(0, B, 8'hFF, 64'h0123456789ABCDEF, 64'h0, 0);
        issue(0, 64'h7FFF_FFF8, 8'h00, 64'h0, 64'h0, 1);
        check("err_low", err[0], 1);
        issue(0, B + 64'h2000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1);
        check("err_sticky", err[0], 1);
        issue(0, B, 8'h00, 64'h0, 64'h0123456789ABCDEF, 1);
        check("err_sticky2", err[0], 1);
        check("wr_cnt_c", wrc[0], 4);
        check("rd_cnt_c", rdc[0], 4);

        // Reset clears flags and counters but not the store
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        check("err_cleared", err[0], 0);
        check("rd_cnt_cleared", rdc[0], 0);
        check("wr_cnt_cleared", wrc[0], 0);
        issue(0, B + 8, 8'h00, 64'h0, 64'h11223344_BBBBBBBB, 1);

        // LATENCY=1: back-to-back reads with valid held
        issue(1, B, 8'hFF, 64'h5555_6666_7777_8888, 64'h0, 0);
        for (int k = 0; k < 4; k++) begin
            aq.push_back('{u: 1, cyc: cyc + 1 + 2*k});
            dq.push_back('{u: 1, cyc: cyc + 1 + 2*k,
                           d: 64'h5555_6666_7777_8888, chk: 1});
        end
        req[1].valid  = 1'b1;
        req[1].addr   = B;
        req[1].strobe = 8'h00;
        repeat (7) @(negedge clk);
        req[1].valid = 1'b0;
        @(negedge clk);
        check("l1_rd_cnt", rdc[1], 4);

        // Reset wins over a same-cycle acceptance
        req[1].valid = 1'b1;
        rst[1]       = 1'b1;
        @(negedge clk);
        req[1].valid = 1'b0;
        rst[1]       = 1'b0;
        check("rst_prio_busy", busy[1], 0);
        @(negedge clk);
        check("rst_prio_busy2", busy[1], 0);

        // LATENCY=3: reset in BUSY abandons a write
        issue(2, B + 64'h10, 8'hFF, 64'hCAFE_F00D_1234_5678, 64'h0, 0);
        aq.push_back('{u: 2, cyc: cyc + 1});
        req[2].valid  = 1'b1;
        req[2].addr   = B + 64'h10;
        req[2].strobe = 8'hFF;
        req[2].data   = 64'h9999_9999_9999_9999;
        @(negedge clk);
        req[2].valid = 1'b0;
        rst[2]       = 1'b1;
        @(negedge clk);
        rst[2] = 1'b0;
        check("abandon_busy", busy[2], 0);
        check("abandon_wr_cnt", wrc[2], 0);
        repeat (4) @(negedge clk);
        issue(2, B + 64'h10, 8'h00, 64'h0, 64'hCAFE_F00D_1234_5678, 1);
        check("abandon_wr_cnt2", wrc[2], 0);
        check("abandon_rd_cnt", rdc[2], 1);

        begin
            int n;
            n = 0;
            while ((aq.size() != 0 || dq.size() != 0) && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        check("aq_drained", 64'(aq.size()), 0);
        check("dq_drained", 64'(dq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
